// File: rtl/ibex_pkg.sv
// Shared IF-stage types and helpers for the fetch buffer and compressed decoder.
package ibex_pkg;

    localparam int unsigned FETCH_FIFO_MIN_DEPTH = 3;

    // One buffered memory response word.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // RISC-V compressed encoding: any low two bits other than 2'b11.
    function automatic logic is_compressed(input logic [15:0] instr);
        logic [13:0] unused_upper;
        unused_upper  = instr[15:2];
        is_compressed = (instr[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/ibex_fetch_fifo.sv
// Instruction fetch buffer: queues memory words and realigns them into
// 16/32-bit instructions for ID. Optional macro IBEX_FETCH_FIFO_BYPASS_EN lets
// an incoming word feed the output in the same cycle when the queue is
// (nearly) empty.
module ibex_fetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        instr_new_o
);

    if (DEPTH < FETCH_FIFO_MIN_DEPTH) begin : g_depth_check
        $error("ibex_fetch_fifo: DEPTH must be at least FETCH_FIFO_MIN_DEPTH");
    end

    fetch_entry_t     entry_q [DEPTH];
    fetch_entry_t     entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      addr_q, addr_d;
    logic             stalled_q, stalled_d;

    fetch_entry_t     in_entry;
    fetch_entry_t     word0, word1;
    logic             valid0, valid1;
    logic             push, push_acc, full;
    logic             unaligned, compressed, instr_valid, fire, pop;
    logic [31:0]      instr;

    // Working queue: stored entries plus one spare slot for the shift.
    fetch_entry_t     q_ent [DEPTH+1];
    logic [DEPTH:0]   q_val;
    logic             placed;

    logic             unused_addr_lsb;
    assign unused_addr_lsb = in_addr_i[0];

    assign in_entry = '{rdata: in_rdata_i, err: in_err_i};
    assign push     = in_valid_i & ~clear_i;
    assign full     = valid_q[DEPTH-1];
    assign push_acc = push & ~full;

    // Select the two head words and realign them into one instruction.
    always_comb begin
        word0  = entry_q[0];
        valid0 = valid_q[0];
        word1  = entry_q[1];
        valid1 = valid_q[1];
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
        if (push && !valid_q[0]) begin
            word0  = in_entry;
            valid0 = 1'b1;
        end else if (push && !valid_q[1]) begin
            word1  = in_entry;
            valid1 = 1'b1;
        end
`endif
        unaligned   = addr_q[1];
        instr       = unaligned ? {word1.rdata[15:0], word0.rdata[31:16]} : word0.rdata;
        compressed  = is_compressed(instr[15:0]);
        instr_valid = valid0 & (~unaligned | compressed | word0.err | valid1);
        fire        = instr_valid & out_ready_i & ~clear_i;
        // Only an aligned compressed instruction leaves its word in place.
        pop         = fire & (unaligned | ~compressed);
    end

    // Append the accepted word, then drop the head word on a pop.
    always_comb begin
        placed = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q_ent[i] = entry_q[i];
            q_val[i] = valid_q[i];
        end
        q_ent[DEPTH] = '0;
        q_val[DEPTH] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_acc && !placed && !valid_q[i]) begin
                q_ent[i] = in_entry;
                q_val[i] = 1'b1;
                placed   = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = pop ? q_ent[i+1] : q_ent[i];
            valid_d[i] = pop ? q_val[i+1] : q_val[i];
        end
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
            valid_d = '0;
        end
    end

    // Next fetch address and first-cycle tracking.
    always_comb begin
        addr_d    = addr_q;
        stalled_d = instr_valid & ~out_ready_i;
        if (fire) begin
            addr_d = addr_q + (compressed ? 32'd2 : 32'd4);
        end
        if (clear_i) begin
            addr_d    = {in_addr_i[31:1], 1'b0};
            stalled_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q   <= '0;
            addr_q    <= '0;
            stalled_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            stalled_q <= stalled_d;
        end
    end

    assign busy_o      = valid_q[DEPTH-2];
    assign out_valid_o = instr_valid;
    assign out_rdata_o = instr;
    assign out_addr_o  = addr_q;
    assign out_err_o   = word0.err | (unaligned & ~compressed & word1.err);
    assign instr_new_o = instr_valid & ~stalled_q;

    // Upstream must honour busy_o; a word arriving with every slot full is lost.
    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && !clear_i && valid_q[DEPTH-1]))
        else $error("ibex_fetch_fifo: response word arrived while full");

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Directed bench for ibex_fetch_fifo (default, non-bypass build).
module tb_ibex_fetch_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [31:0] in_addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic        instr_new_o;

    int unsigned total  = 0;
    int unsigned passed = 0;

    ibex_fetch_fifo #(.DEPTH(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_addr_i   (in_addr_i),
        .in_valid_i  (in_valid_i),
        .in_rdata_i  (in_rdata_i),
        .in_err_i    (in_err_i),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_rdata_o (out_rdata_o),
        .out_addr_o  (out_addr_o),
        .out_err_o   (out_err_o),
        .instr_new_o (instr_new_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i   = 1'b1;
        in_addr_i = addr;
        tick();
        clear_i   = 1'b0;
    endtask

    task automatic push(input logic [31:0] data, input logic err);
        in_valid_i = 1'b1;
        in_rdata_i = data;
        in_err_i   = err;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_addr_i   = '0;
        in_valid_i  = 1'b0;
        in_rdata_i  = '0;
        in_err_i    = 1'b0;
        out_ready_i = 1'b0;
        #22;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_new",   32'(instr_new_o), 32'd0);
        chk("rst_rdata", out_rdata_o,      32'h0);
        chk("rst_addr",  out_addr_o,       32'h0);
        chk("rst_err",   32'(out_err_o),   32'd0);
        rst_ni = 1'b1;
        tick();

        // Aligned 32-bit instruction.
        do_clear(32'h100);
        chk("al_addr0",  out_addr_o,       32'h100);
        chk("al_empty",  32'(out_valid_o), 32'd0);
        push(32'h00A00093, 1'b0);
        chk("al_valid",  32'(out_valid_o), 32'd1);
        chk("al_rdata",  out_rdata_o,      32'h00A00093);
        chk("al_addr",   out_addr_o,       32'h100);
        chk("al_new",    32'(instr_new_o), 32'd1);
        chk("al_busy",   32'(busy_o),      32'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("al_addr4",  out_addr_o,       32'h104);
        chk("al_drain",  32'(out_valid_o), 32'd0);

        // Two compressed instructions in one word.
        do_clear(32'h200);
        push(32'h45014505, 1'b0);
        chk("c0_valid",  32'(out_valid_o), 32'd1);
        chk("c0_rdata",  out_rdata_o,      32'h45014505);
        chk("c0_addr",   out_addr_o,       32'h200);
        chk("c0_new",    32'(instr_new_o), 32'd1);
        out_ready_i = 1'b1;
        tick();
        chk("c1_valid",  32'(out_valid_o), 32'd1);
        chk("c1_rdata",  out_rdata_o,      32'h00004501);
        chk("c1_addr",   out_addr_o,       32'h202);
        chk("c1_new",    32'(instr_new_o), 32'd1);
        tick();
        out_ready_i = 1'b0;
        chk("c_drain",   32'(out_valid_o), 32'd0);
        chk("c_addr",    out_addr_o,       32'h204);

        // Unaligned 32-bit instruction spanning two words; bit 0 of target dropped.
        do_clear(32'h303);
        chk("u_addr0",   out_addr_o,       32'h302);
        push(32'h00931234, 1'b0);
        chk("u_half",    32'(out_valid_o), 32'd0);
        chk("u_hrdata",  out_rdata_o,      32'h00000093);
        push(32'hABCD00A0, 1'b0);
        chk("u_valid",   32'(out_valid_o), 32'd1);
        chk("u_rdata",   out_rdata_o,      32'h00A00093);
        chk("u_addr",    out_addr_o,       32'h302);
        chk("u_new",     32'(instr_new_o), 32'd1);
        chk("u_busy",    32'(busy_o),      32'd1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("u_addr6",   out_addr_o,       32'h306);
        chk("u_next_v",  32'(out_valid_o), 32'd1);
        chk("u_next_d",  out_rdata_o,      32'h0000ABCD);
        chk("u_busy2",   32'(busy_o),      32'd0);

        // Stall for three cycles: instr_new only in the first.
        chk("st_new0",   32'(instr_new_o), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("st_new",   32'(instr_new_o), 32'd0);
            chk("st_valid", 32'(out_valid_o), 32'd1);
            chk("st_rdata", out_rdata_o,      32'h0000ABCD);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("st_addr",   out_addr_o,       32'h308);
        chk("st_drain",  32'(out_valid_o), 32'd0);

        // Bus error on an unaligned 32-bit-looking half with no second word.
        do_clear(32'h402);
        push(32'h00030000, 1'b1);
        chk("e_valid",   32'(out_valid_o), 32'd1);
        chk("e_err",     32'(out_err_o),   32'd1);
        chk("e_rdata",   out_rdata_o,      32'h00000003);

        // Fill to DEPTH, then a clear racing a push and a ready.
        do_clear(32'h500);
        push(32'h00000013, 1'b0);
        chk("f_busy1",   32'(busy_o),      32'd0);
        push(32'h00100093, 1'b0);
        chk("f_busy2",   32'(busy_o),      32'd1);
        push(32'h00200113, 1'b0);
        chk("f_busy3",   32'(busy_o),      32'd1);
        chk("f_head",    out_rdata_o,      32'h00000013);
        clear_i     = 1'b1;
        in_addr_i   = 32'h600;
        in_valid_i  = 1'b1;
        in_rdata_i  = 32'hDEADBEEF;
        out_ready_i = 1'b1;
        tick();
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("cr_valid",  32'(out_valid_o), 32'd0);
        chk("cr_busy",   32'(busy_o),      32'd0);
        chk("cr_addr",   out_addr_o,       32'h600);
        chk("cr_new",    32'(instr_new_o), 32'd0);
        tick();
        chk("cr_stay",   32'(out_valid_o), 32'd0);

        // Pop and push in the same cycle.
        push(32'h00100093, 1'b0);
        out_ready_i = 1'b1;
        push(32'h00200113, 1'b0);
        out_ready_i = 1'b0;
        chk("pp_valid",  32'(out_valid_o), 32'd1);
        chk("pp_rdata",  out_rdata_o,      32'h00200113);
        chk("pp_addr",   out_addr_o,       32'h604);
        chk("pp_new",    32'(instr_new_o), 32'd1);
        chk("pp_busy",   32'(busy_o),      32'd0);

        // Asynchronous reset mid-cycle.
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_valid",  32'(out_valid_o), 32'd0);
        chk("ar_addr",   out_addr_o,       32'h0);
        chk("ar_rdata",  out_rdata_o,      32'h0);
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
